// File: rtl/snake_state_reader_if.sv
// rtl/snake_state_reader_if.sv - readback and scan-stream handshake bundle for snake_state_reader
interface snake_state_reader_if;
    logic        rd_req;
    logic [31:0] rd_index;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_error;
    logic        scan_start;
    logic        scan_valid;
    logic        scan_ready;
    logic [6:0]  scan_index;
    logic [31:0] scan_data;
    logic        scan_last;
    logic        scan_busy;

    modport slave (
        input  rd_req, rd_index, scan_start, scan_ready,
        output rd_valid, rd_data, rd_error,
        output scan_valid, scan_index, scan_data, scan_last, scan_busy
    );

    modport master (
        output rd_req, rd_index, scan_start, scan_ready,
        input  rd_valid, rd_data, rd_error,
        input  scan_valid, scan_index, scan_data, scan_last, scan_busy
    );
endinterface

// File: rtl/snake_state_reader.sv
// rtl/snake_state_reader.sv - indexed readback and snapshot stream dump of the snake game-state bank
module snake_state_reader #(
    parameter int NUM_CELLS = 100,
    parameter int NUM_WORDS = 9,
    parameter int STATE_W   = 2*NUM_CELLS + 32*NUM_WORDS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STATE_W-1:0] snake_state,
    snake_state_reader_if.slave bus
);
    localparam int         NUM_ENTRIES = NUM_CELLS + NUM_WORDS;
    localparam logic [6:0] LAST_IDX    = 7'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, SNAP, STREAM} state_e;

    function automatic logic [31:0] entry_of(input logic [STATE_W-1:0] s, input logic [6:0] i);
        logic [31:0] r;
        r = '0;
        if (int'(i) < NUM_CELLS)
            r = {30'b0, s[2*int'(i) +: 2]};
        else if (int'(i) < NUM_ENTRIES)
            r = s[2*NUM_CELLS + 32*(int'(i) - NUM_CELLS) +: 32];
        return r;
    endfunction

    // readback pipeline: request stage, then mux-result stage feeding the outputs
    logic        req_q, req_d;
    logic [31:0] index_q, index_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rerr_q, rerr_d;

    state_e             state_q, state_d;
    logic [STATE_W-1:0] snap_q, snap_d;
    logic [6:0]         sidx_q, sidx_d;
    logic [31:0]        sdata_q, sdata_d;
    logic               hs;
    logic [6:0]         fetch_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q    <= 1'b0;
            index_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            state_q  <= IDLE;
            snap_q   <= '0;
            sidx_q   <= '0;
            sdata_q  <= '0;
        end else begin
            req_q    <= req_d;
            index_q  <= index_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            state_q  <= state_d;
            snap_q   <= snap_d;
            sidx_q   <= sidx_d;
            sdata_q  <= sdata_d;
        end
    end

    always_comb begin
        req_d    = bus.rd_req;
        index_d  = bus.rd_req ? bus.rd_index : index_q;
        rvalid_d = req_q;
        rerr_d   = req_q && (index_q >= 32'(NUM_ENTRIES));
        rdata_d  = '0;
        if (req_q && !rerr_d)
            rdata_d = entry_of(snake_state, index_q[6:0]);
    end

    always_comb begin
        hs        = (state_q == STREAM) && bus.scan_ready;
        state_d   = state_q;
        snap_d    = snap_q;
        sidx_d    = sidx_q;
        sdata_d   = sdata_q;
        fetch_idx = (state_q == SNAP) ? sidx_q : sidx_q + 7'd1;
        case (state_q)
            IDLE: begin
                if (bus.scan_start) begin
                    snap_d  = snake_state;
                    sidx_d  = '0;
                    state_d = SNAP;
                end
            end
            SNAP: begin
                sdata_d = entry_of(snap_q, fetch_idx);
                state_d = STREAM;
            end
            STREAM: begin
                if (hs) begin
                    if (sidx_q == LAST_IDX) begin
                        sidx_d  = '0;
                        sdata_d = '0;
                        state_d = IDLE;
                    end else begin
                        sidx_d  = fetch_idx;
                        sdata_d = entry_of(snap_q, fetch_idx);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.rd_valid   = rvalid_q;
        bus.rd_data    = rdata_q;
        bus.rd_error   = rerr_q;
        bus.scan_valid = (state_q == STREAM);
        bus.scan_busy  = (state_q != IDLE);
        bus.scan_index = sidx_q;
        bus.scan_data  = sdata_q;
        bus.scan_last  = (state_q == STREAM) && (sidx_q == LAST_IDX);
    end
endmodule

// File: tb/tb_snake_state_reader.sv
// tb/tb_snake_state_reader.sv - directed self-checking bench for snake_state_reader
module tb_snake_state_reader;
    logic         clock;
    logic         reset;
    logic [487:0] snake_state;
    snake_state_reader_if bus();

    snake_state_reader dut (
        .clock(clock),
        .reset(reset),
        .snake_state(snake_state),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_cyc;
    logic [39:0] beats[$];
    logic        prev_stall = 1'b0;
    logic [6:0]  prev_idx;
    logic [31:0] prev_data;
    logic        rnd_on = 1'b0;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_entry(input logic [487:0] s, input int i);
        if (i < 100) return {30'b0, s[2*i +: 2]};
        if (i < 109) return s[200 + 32*(i-100) +: 32];
        return 32'h0;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", bus.scan_valid, 1'b1);
                chk("stall_idx", bus.scan_index, prev_idx);
                chk("stall_data", bus.scan_data, prev_data);
            end
            if (bus.scan_valid && bus.scan_ready)
                beats.push_back({bus.scan_last, bus.scan_index, bus.scan_data});
            prev_stall = bus.scan_valid && !bus.scan_ready;
            prev_idx   = bus.scan_index;
            prev_data  = bus.scan_data;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rnd_on) bus.scan_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_rd"}, {bus.rd_valid, bus.rd_error, bus.rd_data}, 64'h0);
        chk({tag, "_scan"}, {bus.scan_valid, bus.scan_busy, bus.scan_last, bus.scan_index, bus.scan_data}, 64'h0);
    endtask

    task automatic read_one(input string tag, input logic [31:0] idx, input logic [31:0] ed, input logic ee);
        bus.rd_req = 1'b1;
        bus.rd_index = idx;
        @(posedge clock);
        #1 bus.rd_req = 1'b0;
        @(negedge clock);
        chk({tag, "_lat"}, bus.rd_valid, 1'b0);
        @(negedge clock);
        chk(tag, {bus.rd_valid, bus.rd_error, bus.rd_data}, {1'b1, ee, ed});
        @(posedge clock);
        #1;
    endtask

    task automatic start_scan(input string tag);
        beats.delete();
        bus.scan_start = 1'b1;
        @(posedge clock);
        #1 bus.scan_start = 1'b0;
        @(negedge clock);
        chk({tag, "_busy0"}, {bus.scan_busy, bus.scan_valid}, 2'b10);
        @(negedge clock);
        first_cyc = cyc;
        chk({tag, "_beat0"}, {bus.scan_valid, bus.scan_index}, {1'b1, 7'd0});
    endtask

    task automatic wait_scan_end(input string tag, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clock);
            if (bus.scan_valid && bus.scan_last && bus.scan_ready) break;
        end
        if (n >= budget) chk({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic check_beats(input string tag, input logic [487:0] snap);
        chk({tag, "_count"}, beats.size(), 109);
        for (int k = 0; k < 109 && k < beats.size(); k++)
            chk($sformatf("%s_b%0d", tag, k), beats[k], {k == 108, 7'(k), exp_entry(snap, k)});
    endtask

    logic [487:0] snap;

    initial begin
        reset = 1'b1;
        snake_state = '0;
        bus.rd_req = 1'b0;
        bus.rd_index = '0;
        bus.scan_start = 1'b0;
        bus.scan_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_idle("reset");
        @(posedge clock);
        #1 reset = 1'b0;

        // 1) back-to-back readback
        snake_state[7:6] = 2'b10;
        snake_state[231:200] = 32'h0000_0037;
        @(posedge clock);
        #1 bus.rd_req = 1'b1;
        bus.rd_index = 32'd3;
        @(negedge clock);
        chk("t1_lat0", bus.rd_valid, 1'b0);
        @(posedge clock);
        #1 bus.rd_index = 32'd100;
        @(negedge clock);
        chk("t1_lat1", bus.rd_valid, 1'b0);
        @(posedge clock);
        #1 bus.rd_req = 1'b0;
        @(negedge clock);
        chk("t1_idx3", {bus.rd_valid, bus.rd_error, bus.rd_data}, {2'b10, 32'h2});
        @(negedge clock);
        chk("t1_idx100", {bus.rd_valid, bus.rd_error, bus.rd_data}, {2'b10, 32'h37});
        @(negedge clock);
        chk("t1_done", bus.rd_valid, 1'b0);
        @(posedge clock);
        #1;

        // 2) out-of-range indices
        read_one("t2_109", 32'd109, 32'h0, 1'b1);
        read_one("t2_ffff", 32'hFFFF_FFFF, 32'h0, 1'b1);
        read_one("t2_108", 32'd108, 32'h0, 1'b0);

        // 3) full stream, ready high; start pulse during final handshake must be ignored
        for (int w = 0; w < 16; w++) snake_state[32*w +: 32] = $urandom;
        snake_state[487:480] = 8'hA5;
        snap = snake_state;
        start_scan("t3");
        wait_scan_end("t3", 300);
        bus.scan_start = 1'b1;
        chk("t3_cycles", cyc - first_cyc, 108);
        @(posedge clock);
        #1 bus.scan_start = 1'b0;
        @(negedge clock);
        chk("t3_end", {bus.scan_busy, bus.scan_valid, bus.scan_last}, 3'b000);
        repeat (2) @(negedge clock);
        chk("t3_no_restart", bus.scan_busy, 1'b0);
        check_beats("t3", snap);
        @(posedge clock);
        #1;

        // 4) live writes during stream: stream keeps snapshot, readback sees new values
        snake_state[1:0] = 2'b01;
        snake_state[487:456] = 32'h0000_1234;
        snap = snake_state;
        start_scan("t4");
        snake_state[1:0] = 2'b11;
        snake_state[487:456] = 32'hDEAD_0007;
        @(posedge clock);
        #1;
        read_one("t4_rd_cell0", 32'd0, 32'h3, 1'b0);
        read_one("t4_rd_timer", 32'd108, 32'hDEAD_0007, 1'b0);
        wait_scan_end("t4", 300);
        @(negedge clock);
        check_beats("t4", snap);
        @(posedge clock);
        #1;

        // 5) random back-pressure with stray starts and state changes mid-stream
        for (int w = 0; w < 16; w++) snake_state[32*w +: 32] = $urandom;
        snap = snake_state;
        rnd_on = 1'b1;
        start_scan("t5");
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock);
            if (bus.scan_valid && bus.scan_last && bus.scan_ready) break;
            bus.scan_start = (n == 3 || n == 40 || n == 150);
            if (n == 10) snake_state = ~snake_state;
        end
        bus.scan_start = 1'b0;
        rnd_on = 1'b0;
        repeat (2) @(negedge clock);
        chk("t5_idle", bus.scan_busy, 1'b0);
        check_beats("t5", snap);
        @(posedge clock);
        #1 bus.scan_ready = 1'b1;

        // 6) reset mid-stream at beat 50, then a fresh scan
        start_scan("t6a");
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (bus.scan_valid && bus.scan_index == 7'd50) break;
        end
        chk("t6_at50", bus.scan_index, 7'd50);
        reset = 1'b1;
        #1 check_idle("t6_async");
        @(posedge clock);
        #1 reset = 1'b0;
        beats.delete();
        repeat (3) @(negedge clock);
        check_idle("t6_after");
        chk("t6_no_beats", beats.size(), 0);
        for (int w = 0; w < 16; w++) snake_state[32*w +: 32] = $urandom;
        snap = snake_state;
        @(posedge clock);
        #1;
        start_scan("t6b");
        wait_scan_end("t6b", 300);
        @(negedge clock);
        check_beats("t6b", snap);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
